// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule types, sizes and GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} key_exp_state_e;

  localparam int AES256_NUM_RK   = 15;
  localparam int AES256_NUM_ITER = 7;

  typedef logic [0:127] round_key_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes256_key_expander_round_key.sv
// One AES-256 key-schedule step: eight previous words in, next eight words out.
module round_key
  import aes_pkg::*;
(
  input  logic [0:255] k_i,
  input  logic [3:0]   r_i,
  output logic [0:255] result_o
);

  logic [31:0] w [8];
  logic [31:0] n [8];
  logic [7:0]  rc;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w[i] = k_i[32*i +: 32];
    end
    // r_i stays in 1..7 so the round constant never needs GF reduction.
    rc   = 8'h01 << (r_i - 4'd1);
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rc, 24'h000000};
    n[1] = w[1] ^ n[0];
    n[2] = w[2] ^ n[1];
    n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ sub_word(n[3]);
    n[5] = w[5] ^ n[4];
    n[6] = w[6] ^ n[5];
    n[7] = w[7] ^ n[6];
    result_o = '0;
    for (int i = 0; i < 8; i++) begin
      result_o[32*i +: 32] = n[i];
    end
  end

endmodule

// File: rtl/aes256_key_expander.sv
// Sequential AES-256 key schedule: one round_key step per cycle into a 15-entry
// round-key bank that the cipher datapath reads by index.
module aes256_key_expander
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [0:255] key_i,
  input  logic         key_v_i,
  output logic         key_ready_o,
  input  logic         clear_i,
  input  logic [3:0]   rk_idx_i,
  output logic [0:127] rk_o,
  output logic         keys_v_o,
  output logic         busy_o
);

  localparam int NUM_RK   = AES256_NUM_RK;
  localparam int NUM_ITER = AES256_NUM_ITER;

  key_exp_state_e state_q, state_d;
  logic [3:0]     r_cnt_q;
  logic [0:255]   work_q;
  round_key_t     bank_q [NUM_RK];
  logic [0:255]   step;
  logic           accept;
  logic           last_iter;
  logic [3:0]     idx_lo;
  logic [3:0]     idx_hi;

  round_key u_round_key (
    .k_i      (work_q),
    .r_i      (r_cnt_q),
    .result_o (step)
  );

  // key_ready_o depends only on state_q, so key_v_i never reaches it combinationally.
  assign accept    = key_v_i & key_ready_o & ~clear_i;
  assign last_iter = (r_cnt_q == 4'(NUM_ITER));
  assign idx_lo    = {r_cnt_q[2:0], 1'b0};
  assign idx_hi    = {r_cnt_q[2:0], 1'b1};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = EXPAND;
        EXPAND:  if (last_iter) state_d = DONE;
        DONE:    if (accept) state_d = EXPAND;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready_o = (state_q != EXPAND);
    busy_o      = (state_q == EXPAND);
    keys_v_o    = (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt_q <= 4'd1;
      work_q  <= '0;
      for (int i = 0; i < NUM_RK; i++) begin
        bank_q[i] <= '0;
      end
    end else if (clear_i) begin
      r_cnt_q <= 4'd1;
    end else if (accept) begin
      work_q    <= key_i;
      bank_q[0] <= key_i[0:127];
      bank_q[1] <= key_i[128:255];
      r_cnt_q   <= 4'd1;
    end else if (state_q == EXPAND) begin
      work_q         <= step;
      bank_q[idx_lo] <= step[0:127];
      // The last step's upper half would be entry 15, which AES-256 does not use.
      if (!last_iter) begin
        bank_q[idx_hi] <= step[128:255];
      end
      r_cnt_q <= last_iter ? 4'd1 : r_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rk_o = '0;
    for (int i = 0; i < NUM_RK; i++) begin
      if (rk_idx_i == 4'(i)) rk_o = bank_q[i];
    end
  end

endmodule
